// File: rtl/rv_fetch_unit.sv
// Prefetch FIFO with flush; head is visible combinationally, so push-to-valid is one cycle.
// A push and a pop may share a cycle at any occupancy. The producer must hold a credit before it pushes.
module rv_fetch_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push_vld,
    input  logic [WIDTH-1:0]         push_dat,
    output logic                     pop_vld,
    input  logic                     pop_rdy,
    output logic [WIDTH-1:0]         pop_dat,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             pop;

    assign pop_vld = (count_q != '0);
    assign pop_dat = mem_q[rd_ptr_q];
    assign count   = count_q;
    assign pop     = pop_vld && pop_rdy;

    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            // When full with a pop, the write lands on the slot being read out this cycle.
            if (push_vld) begin
                mem_d[wr_ptr_q] = push_dat;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            count_d = count_q + (AW+1)'(push_vld) - (AW+1)'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end
endmodule

// RV32I fetch front end: sequential word fetch over req/gnt, responses buffered in a prefetch FIFO.
// Response to instr_valid is one cycle, with no bypass. Redirect takes effect on the following cycle.
// Requests are throttled so that FIFO entries plus live in-flight requests never exceed DEPTH.
module rv_fetch_unit #(
    parameter int unsigned      XLEN     = 32,
    parameter int unsigned      DEPTH    = 4,
    parameter logic [XLEN-1:0]  RESET_PC = '0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    output logic                    imem_req,
    output logic [XLEN-1:0]         imem_addr,
    input  logic                    imem_gnt,
    input  logic                    imem_rvalid,
    input  logic [31:0]             imem_rdata,
    input  logic                    redirect_valid,
    input  logic [XLEN-1:0]         redirect_pc,
    output logic                    instr_valid,
    output logic [31:0]             instr,
    output logic [XLEN-1:0]         instr_pc,
    input  logic                    instr_ready,
    output logic [XLEN-1:0]         fetch_pc,
    output logic [$clog2(DEPTH):0]  fifo_count
);
    // Stale requests from repeated redirects can pile up beyond DEPTH, so the counters get headroom.
    localparam int unsigned OST_W = $clog2(DEPTH) + 3;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     word;
    } fetch_entry_t;

    logic [XLEN-1:0]  pc_q, pc_d;
    logic [XLEN-1:0]  resp_pc_q, resp_pc_d;
    logic [OST_W-1:0] outstanding_q, outstanding_d;
    logic [OST_W-1:0] drop_cnt_q, drop_cnt_d;
    logic [OST_W-1:0] in_use;
    logic [XLEN-1:0]  target;
    logic             grant;
    logic             resp_ok;
    logic             push;
    fetch_entry_t     push_entry;
    fetch_entry_t     head_entry;

    always_comb begin
        target    = redirect_pc & ~XLEN'(3);
        in_use    = OST_W'(fifo_count) + outstanding_q - drop_cnt_q;
        imem_req  = rst_n && !redirect_valid && (in_use < OST_W'(DEPTH));
        grant     = imem_req && imem_gnt;
        resp_ok   = imem_rvalid && (outstanding_q != '0);
        push      = resp_ok && (drop_cnt_q == '0) && !redirect_valid;
        push_entry.pc   = resp_pc_q;
        push_entry.word = imem_rdata;

        pc_d          = pc_q;
        resp_pc_d     = resp_pc_q;
        drop_cnt_d    = drop_cnt_q;
        outstanding_d = outstanding_q + OST_W'(grant) - OST_W'(resp_ok);
        if (redirect_valid) begin
            pc_d       = target;
            resp_pc_d  = target;
            drop_cnt_d = outstanding_q - OST_W'(resp_ok);
        end else begin
            if (grant) begin
                pc_d = pc_q + XLEN'(4);
            end
            if (push) begin
                resp_pc_d = resp_pc_q + XLEN'(4);
            end
            if (resp_ok && (drop_cnt_q != '0)) begin
                drop_cnt_d = drop_cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q          <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
        end else begin
            pc_q          <= pc_d;
            resp_pc_q     <= resp_pc_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && imem_rvalid) begin
            assert (outstanding_q != '0);
        end
    end

    rv_fetch_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (redirect_valid),
        .push_vld (push),
        .push_dat (push_entry),
        .pop_vld  (instr_valid),
        .pop_rdy  (instr_ready),
        .pop_dat  (head_entry),
        .count    (fifo_count)
    );

    assign imem_addr = pc_q;
    assign fetch_pc  = pc_q;
    assign instr     = head_entry.word;
    assign instr_pc  = head_entry.pc;
endmodule

// File: tb/tb_rv_fetch_unit.sv
// Bench for rv_fetch_unit: a memory model with 1-cycle latency and an optional response hold.
// The scoreboard holds expected {pc, word} pairs; the monitor checks every accepted instruction against it.
module tb_rv_fetch_unit;
    localparam int          XLEN     = 32;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] XOR_K    = 32'hA5A5_0000;
    localparam int          MEM_LAT  = 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;
    logic [31:0] fetch_pc;
    logic [2:0]  fifo_count;

    rv_fetch_unit #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
        .instr_ready(instr_ready), .fetch_pc(fetch_pc), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] pc; logic [31:0] word; } exp_t;
    typedef struct { logic [31:0] addr; int due; } pend_t;

    exp_t        exp_q[$];
    pend_t       pend_q[$];
    int          rd_idx = 0;
    int          flush_to = 0;
    int          flush_gen = 0;
    int          flush_seen = 0;
    int          cyc = 0;
    int          gnt_cnt = 0;
    int          gnt_base = 0;
    logic        mem_hold = 1'b0;
    int          checks = 0;
    int          failures = 0;
    logic [31:0] saved_addr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic expect_seq(input logic [31:0] start, input int n);
        for (int i = 0; i < n; i++) begin
            exp_t e;
            e.pc   = start + 32'(4 * i);
            e.word = e.pc ^ XOR_K;
            exp_q.push_back(e);
        end
    endtask

    task automatic flush_exp();
        flush_to = exp_q.size();
        flush_gen++;
    endtask

    task automatic wait_drain(input string name, input int max_cyc);
        int n;
        n = 0;
        while (rd_idx < exp_q.size() && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (rd_idx < exp_q.size()) begin
            failures++;
            $display("FAIL %s timeout delivered=%0d required=%0d", name, rd_idx, exp_q.size());
        end
    endtask

    // Memory: presents at most one in-order response per cycle, then records this cycle's grant.
    task automatic memory();
        forever begin
            @(negedge clk);
            #1;
            cyc++;
            imem_rvalid = 1'b0;
            imem_rdata  = '0;
            if (!rst_n) begin
                pend_q.delete();
            end else begin
                if (!mem_hold && pend_q.size() > 0 && pend_q[0].due <= cyc) begin
                    imem_rvalid = 1'b1;
                    imem_rdata  = pend_q[0].addr ^ XOR_K;
                    void'(pend_q.pop_front());
                end
                if (imem_req && imem_gnt) begin
                    pend_t p;
                    p.addr = imem_addr;
                    p.due  = cyc + MEM_LAT;
                    pend_q.push_back(p);
                    gnt_cnt++;
                end
            end
        end
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk);
            #3;
            if (flush_seen != flush_gen) begin
                rd_idx     = flush_to;
                flush_seen = flush_gen;
            end
            if (rst_n && instr_valid && instr_ready && !redirect_valid && rd_idx < exp_q.size()) begin
                check("sb_instr_pc", instr_pc, exp_q[rd_idx].pc);
                check("sb_instr", instr, exp_q[rd_idx].word);
                rd_idx++;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        imem_gnt       = 1'b0;
        instr_ready    = 1'b0;
        mem_hold       = 1'b0;
        @(negedge clk);
        #3;
        check("rst_instr_valid", 32'(instr_valid), 32'd0);
        check("rst_imem_req", 32'(imem_req), 32'd0);
        check("rst_fifo_count", 32'(fifo_count), 32'd0);
        check("rst_fetch_pc", fetch_pc, RESET_PC);
        @(negedge clk);
        rst_n    = 1'b1;
        gnt_base = gnt_cnt;
        flush_exp();
    endtask

    initial begin
        rst_n          = 1'b0;
        imem_gnt       = 1'b0;
        imem_rvalid    = 1'b0;
        imem_rdata     = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        instr_ready    = 1'b0;
        fork
            memory();
            monitor();
        join_none

        // Streaming: first instr two cycles after the first grant, then one per cycle.
        do_reset();
        imem_gnt = 1'b1; instr_ready = 1'b1;
        expect_seq(RESET_PC, 8);
        #3;
        check("t1_req", 32'(imem_req), 32'd1);
        check("t1_addr", imem_addr, RESET_PC);
        @(negedge clk); #3;
        check("t1_valid_c1", 32'(instr_valid), 32'd0);
        @(negedge clk); #3;
        check("t1_valid_c2", 32'(instr_valid), 32'd1);
        check("t1_pc_c2", instr_pc, RESET_PC);
        @(negedge clk); #3;
        check("t1_valid_c3", 32'(instr_valid), 32'd1);
        check("t1_pc_c3", instr_pc, RESET_PC + 32'd4);
        wait_drain("t1_drain", 30);

        // Decode stalled: credit limit stops fetch at DEPTH grants.
        do_reset();
        imem_gnt = 1'b1;
        repeat (8) @(negedge clk);
        #3;
        check("t2_grants", 32'(gnt_cnt - gnt_base), 32'd4);
        check("t2_req", 32'(imem_req), 32'd0);
        check("t2_fifo_count", 32'(fifo_count), 32'd4);
        check("t2_fetch_pc", fetch_pc, 32'd16);
        @(negedge clk);
        expect_seq(RESET_PC, 6);
        instr_ready = 1'b1;
        wait_drain("t2_drain", 30);

        // Grant stall: address and pc hold, nothing enters the FIFO.
        @(negedge clk);
        imem_gnt = 1'b0;
        repeat (6) @(negedge clk);
        instr_ready = 1'b0;
        #3;
        saved_addr = imem_addr;
        check("t3_req_start", 32'(imem_req), 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #3;
            check("t3_req", 32'(imem_req), 32'd1);
            check("t3_addr_stable", imem_addr, saved_addr);
            check("t3_fetch_pc_stable", fetch_pc, saved_addr);
            check("t3_fifo_count", 32'(fifo_count), 32'd0);
        end
        @(negedge clk);
        flush_exp();
        expect_seq(saved_addr, 3);
        imem_gnt = 1'b1; instr_ready = 1'b1;
        wait_drain("t3_drain", 30);

        // Redirect with two in flight and one buffered; unaligned target.
        do_reset();
        imem_gnt = 1'b1;
        @(negedge clk); imem_gnt = 1'b0;
        @(negedge clk); imem_gnt = 1'b1; mem_hold = 1'b1;
        @(negedge clk); #3;
        check("t4_fifo_before", 32'(fifo_count), 32'd1);
        @(negedge clk);
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0103;
        #3;
        check("t4_req_during_redirect", 32'(imem_req), 32'd0);
        @(negedge clk);
        redirect_valid = 1'b0; mem_hold = 1'b0; instr_ready = 1'b1;
        flush_exp();
        expect_seq(32'h0000_0100, 2);
        #3;
        check("t4_fifo_flushed", 32'(fifo_count), 32'd0);
        check("t4_valid_after", 32'(instr_valid), 32'd0);
        check("t4_fetch_pc", fetch_pc, 32'h0000_0100);
        check("t4_req_resume", 32'(imem_req), 32'd1);
        check("t4_addr_resume", imem_addr, 32'h0000_0100);
        @(negedge clk); #3;
        check("t4_stale1_dropped", 32'(instr_valid), 32'd0);
        @(negedge clk); #3;
        check("t4_stale2_dropped", 32'(instr_valid), 32'd0);
        wait_drain("t4_drain", 20);

        // Redirect coinciding with a response and a pop.
        repeat (3) @(negedge clk);
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
        flush_exp();
        expect_seq(32'h0000_0200, 3);
        #3;
        check("t5_valid_at_redirect", 32'(instr_valid), 32'd1);
        check("t5_req_at_redirect", 32'(imem_req), 32'd0);
        @(negedge clk);
        redirect_valid = 1'b0;
        #3;
        check("t5_valid_after", 32'(instr_valid), 32'd0);
        check("t5_fifo_after", 32'(fifo_count), 32'd0);
        check("t5_fetch_pc", fetch_pc, 32'h0000_0200);
        check("t5_req_after", 32'(imem_req), 32'd1);
        wait_drain("t5_drain", 20);

        // Reset with the FIFO full, then with three requests held in flight.
        do_reset();
        imem_gnt = 1'b1;
        repeat (8) @(negedge clk);
        #3;
        check("t6_full_before", 32'(fifo_count), 32'd4);
        do_reset();
        imem_gnt = 1'b1; instr_ready = 1'b1;
        expect_seq(RESET_PC, 3);
        #3;
        check("t6_restart_addr", imem_addr, RESET_PC);
        wait_drain("t6_drain_a", 20);

        do_reset();
        imem_gnt = 1'b1; mem_hold = 1'b1;
        repeat (3) @(negedge clk);
        imem_gnt = 1'b0;
        #3;
        check("t6_held_grants", 32'(gnt_cnt - gnt_base), 32'd3);
        do_reset();
        imem_gnt = 1'b1; instr_ready = 1'b1;
        expect_seq(RESET_PC, 3);
        wait_drain("t6_drain_b", 20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/rv_fetch_unit.md
Name: rv_fetch_unit

Overview:
Parametrised instruction-fetch front end for the RV32I core. It generates sequential fetch addresses and issues them over a request/grant instruction-memory port with multiple requests in flight. Returned words go into a DEPTH-entry prefetch FIFO that feeds decode through a valid/ready handshake. Redirect from branch/jump resolution flushes the FIFO and discards stale in-flight responses.

Parameters:
XLEN, 32, address/data width (instructions are 32 bit; XLEN fixed at 32 for RV32I)
DEPTH, 4, prefetch FIFO entries and maximum outstanding requests; power of two, >= 2
RESET_PC, 32'h0000_0000, first fetch address after reset

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  synchronous active-low reset
imem_req  out  1  fetch request valid
imem_addr  out  XLEN  fetch address, word aligned
imem_gnt  in  1  memory accepts request this cycle
imem_rvalid  in  1  response valid; in order; earliest one cycle after grant
imem_rdata  in  32  response instruction word
redirect_valid  in  1  control-flow redirect, single-cycle pulse
redirect_pc  in  XLEN  redirect target; bits [1:0] ignored, treated as 0
instr_valid  out  1  FIFO head valid
instr  out  32  FIFO head instruction
instr_pc  out  XLEN  address of instr
instr_ready  in  1  decode consumes head when instr_valid && instr_ready
fetch_pc  out  XLEN  next address to be requested (pc_q)
fifo_count  out  $clog2(DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (rst_n=0 at posedge): pc_q=RESET_PC, resp_pc_q=RESET_PC, FIFO empty, outstanding=0, drop_cnt=0. Outputs: imem_req=0, instr_valid=0, fifo_count=0, fetch_pc=RESET_PC. Reset mid-operation discards everything; the memory side is reset on the same rst_n.
- Request: imem_req = rst_n && !redirect_valid && (fifo_count + outstanding - drop_cnt) < DEPTH. imem_addr = pc_q. Once imem_req is high, imem_addr holds stable until grant or redirect.
- Grant (imem_req && imem_gnt): pc_q += 4 (wraps modulo 2^XLEN). outstanding += 1.
- Response (imem_rvalid): outstanding -= 1. If drop_cnt>0: discard, drop_cnt -= 1. Else push {resp_pc_q, imem_rdata} into FIFO, resp_pc_q += 4.
- Credit rule: non-dropped in-flight requests plus FIFO entries never exceed DEPTH, so the FIFO cannot overflow. A pop frees credit from the next cycle only, because occupancy is registered.
- Output: instr_valid = (fifo_count != 0). instr/instr_pc = head entry. Pop on instr_valid && instr_ready. Push and pop in the same cycle are legal at any occupancy, including full. Response-to-instr_valid latency is 1 cycle; there is no bypass.
- Redirect (priority over everything in the same cycle):
  - FIFO flushed; any same-cycle pop or push is ignored.
  - imem_req forced 0.
  - pc_q and resp_pc_q are set to {redirect_pc[XLEN-1:2],2'b00}.
  - drop_cnt = outstanding - (imem_rvalid ? 1 : 0). Every remaining in-flight response becomes stale.
  - instr_valid=0 the following cycle.
  - Fetch resumes at the target the cycle after the redirect.
  - Back-to-back redirects: the last one wins; drop_cnt is recomputed each time.
- Protocol violations: imem_rvalid with outstanding==0 is an assertion failure and must not underflow.

Test Plan:
1. Reset with RESET_PC=0; gnt=1, 1-cycle memory returning word = addr^32'hA5A5_0000; instr_ready=1 -> instr_pc 0,4,8,12... with matching instr; first instr_valid 2 cycles after first grant; steady state 1 instr/cycle.
2. DEPTH=4, instr_ready=0 -> exactly 4 grants, then imem_req=0, fifo_count=4, fetch_pc=16. Raise instr_ready -> PCs 0,4,8,12 delivered in order, fetching resumes.
3. Grant stall: imem_gnt=0 for 3 cycles with imem_req=1 -> imem_addr stable, fetch_pc unchanged, no FIFO push.
4. Redirect to 0x100 with 2 requests outstanding and 1 FIFO entry -> FIFO empty next cycle. Next 2 rvalids are dropped. First delivered instr_pc=0x100, then 0x104. redirect_pc=0x103 also yields 0x100.
5. Same cycle: redirect_valid, imem_rvalid, and a pop with instr_ready=1 -> the response is discarded, drop_cnt = outstanding-1, no spurious instr_valid.
6. Reset asserted mid-stream with FIFO full and 3 outstanding -> next cycle: instr_valid=0, imem_req=0, fifo_count=0, fetch_pc=RESET_PC. After release, fetch restarts at RESET_PC.
